abr_ahb_cmd_loader: RTL
=======================

Name: abr_ahb_cmd_loader

Overview:
- AHB-lite single-master sequencer directly upstream of abr_top's AHB slave port.
- On start, it pulls N 32-bit words from a valid/ready stream and writes them to consecutive slave addresses from a base (e.g. the private-key buffer at 0x4000).
- It then writes a command word to the CTRL register and optionally polls a STATUS register until a valid bit is set.
- Replaces software/bench AHB driving for key-load + command-issue sequences.

Parameters:
- AHB_ADDR_WIDTH, 32, address bus width.
- AHB_DATA_WIDTH, 64, data bus width; 32-bit transfers on lane selected by haddr[2].
- CTRL_ADDR, 32'h10, command register address.
- STATUS_ADDR, 32'h14, status register address polled after the command write.
- STATUS_VALID_BIT, 1, status bit index that terminates polling.
- CNT_W, 12, width of the word-count input.
- POLL_LIMIT, 1024, maximum status reads before an error is declared.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  request a sequence; sampled only in IDLE.
- cmd_i  in  32  command word written to CTRL_ADDR.
- base_addr_i  in  AHB_ADDR_WIDTH  first data-word address; bits[1:0] forced to 0.
- word_cnt_i  in  CNT_W  number of data words N; 0 means command only.
- poll_en_i  in  1  enable status polling after the command write.
- src_data_i  in  32  data-word stream.
- src_valid_i  in  1  stream valid.
- src_ready_o  out  1  stream ready.
- haddr_o  out  AHB_ADDR_WIDTH  AHB address.
- hwdata_o  out  AHB_DATA_WIDTH  AHB write data.
- hsel_o  out  1  AHB select.
- hwrite_o  out  1  AHB write.
- htrans_o  out  2  AHB transfer type; 2 = NONSEQ, 0 = IDLE.
- hsize_o  out  3  AHB size; always 3'b010.
- hreadyout_i  in  1  slave ready; also serves as the bus hready.
- hresp_i  in  1  slave error response.
- hrdata_i  in  AHB_DATA_WIDTH  slave read data.
- busy_o  out  1  high from start acceptance until DONE/ERR.
- done_o  out  1  one-cycle pulse on success.
- err_o  out  1  one-cycle pulse on failure.
- status_o  out  32  last polled status word.

Behaviour:
- Reset values:
  - hsel_o = 0, htrans_o = 0, hwrite_o = 0, hsize_o = 3'b010.
  - haddr_o = 0, hwdata_o = 0.
  - src_ready_o = 0, busy_o = 0, done_o = 0, err_o = 0, status_o = 0.
  - FSM in IDLE; index counter cleared.
- Reset mid-operation: the bus returns to IDLE at the next edge; no transfer is completed.
- FSM states: IDLE, FETCH, WR_ADDR, WR_DATA, CMD_ADDR, CMD_DATA, POLL_ADDR, POLL_DATA, DONE, ERR.
- IDLE:
  - start_i=1 latches cmd_i, base_addr_i, word_cnt_i, poll_en_i; clears idx and poll counter; sets busy_o.
  - Next state is FETCH if N>0, otherwise CMD_ADDR.
  - start_i is ignored in every other state.
- FETCH:
  - src_ready_o=1 in this state only.
  - On src_valid_i & src_ready_o, capture src_data_i into a hold register and go to WR_ADDR.
- Address phase (WR_ADDR, CMD_ADDR, POLL_ADDR):
  - Drive hsel_o=1, htrans_o=2, hsize_o=3'b010.
  - hwrite_o=1 for writes, 0 for POLL_ADDR.
  - haddr_o = base+4*idx (mod 2^AHB_ADDR_WIDTH, wraps silently), CTRL_ADDR, or STATUS_ADDR respectively.
  - While hreadyout_i=0: hold all signals stable.
  - On hreadyout_i=1: advance to the matching data phase.
- Data phase (WR_DATA, CMD_DATA, POLL_DATA):
  - Drive hsel_o=1, htrans_o=0, hwrite_o=0.
  - hwdata_o = {word,32'h0} if the latched haddr[2]=1, else {32'h0,word}; stays stable until completion.
  - Completion = first cycle with hreadyout_i=1.
  - hresp_i=1 in any data-phase cycle goes to ERR.
- After WR_DATA completion: idx++; go to FETCH if idx<N, else CMD_ADDR.
- After CMD_DATA completion: go to POLL_ADDR if poll_en, else DONE.
- After POLL_DATA completion:
  - status_o <= selected 32-bit lane of hrdata_i, chosen by STATUS_ADDR[2].
  - If STATUS_VALID_BIT is set, go to DONE.
  - Else increment the poll count; if count reaches POLL_LIMIT go to ERR, otherwise go to POLL_ADDR.
- DONE: done_o=1 for one cycle, busy_o=0; go to IDLE.
- ERR: err_o=1 for one cycle, busy_o=0; go to IDLE. No further transfers; remaining stream words are not consumed.
- Latency (zero wait states, src_valid_i constant high, poll off): done_o is high in cycle 3N+3 after the edge that samples start_i. Each data word takes 3 cycles.
- Each wait-state cycle (hreadyout_i=0) adds exactly one cycle.

Test Plan:
1. Basic load and command:
   - Stimulus: N=4, base=0x4000, stream 0x11,0x22,0x33,0x44, cmd=1, poll off, zero wait.
   - Response: writes at 0x4000/4004/4008/400C; hwdata 0x0000000000000011, 0x0000002200000000, ...; then 0x1 to 0x10; done_o in cycle 15; busy_o low after.
2. Wait states:
   - Stimulus: slave drops hreadyout_i for 2 cycles in every data phase, N=2.
   - Response: haddr/hwdata stable throughout; done_o in cycle 9+6=15; exactly 3 write transfers.
3. Stream gaps, N=0, and restart:
   - Stimulus: src_valid_i low 5 cycles before word 1.
   - Response: FETCH holds, no bus activity, done_o delayed by 5 cycles.
   - Stimulus: N=0, cmd=2.
   - Response: single write of 2 to 0x10; done_o in cycle 3.
   - Stimulus: start_i pulsed while busy.
   - Response: ignored.
4. Error response:
   - Stimulus: hresp_i=1 during the data phase of word index 1, N=4.
   - Response: err_o one-cycle pulse; no CTRL write; src_ready_o stays 0; only 2 stream words consumed.
5. Polling:
   - Stimulus: poll on, status reads 0,0,0 then 0x2.
   - Response: 4 reads of 0x14; status_o=0x2; done_o.
   - Stimulus: POLL_LIMIT=4 with status always 0.
   - Response: exactly 4 reads, then err_o.
6. Reset mid-sequence:
   - Stimulus: rst=1 during WR_DATA of word 2.
   - Response: next cycle all outputs at reset values; a new start then runs the full sequence from idx 0.

Source files
------------

// File: rtl/abr_ahb_cmd_loader.sv
// abr_ahb_cmd_loader: single-master AHB-lite sequencer. Streams N words from a
// valid/ready source to base+4*idx, writes a command to CTRL_ADDR, then
// optionally polls STATUS_ADDR until STATUS_VALID_BIT is set.
// Latency: 3 cycles per data word plus 3 for the command; each poll adds 2;
// every hreadyout_i=0 cycle adds one. Backpressure: src_ready_o is raised only
// in FETCH; all bus outputs are held stable while the slave stalls.
// Ports: clk/rst (sync, active high); start_i/cmd_i/base_addr_i/word_cnt_i/
// poll_en_i sequence request; src_* data stream; h* AHB master signals;
// busy_o/done_o/err_o/status_o sequence status.
module abr_ahb_cmd_loader #(
    parameter int unsigned AHB_ADDR_WIDTH   = 32,
    parameter int unsigned AHB_DATA_WIDTH   = 64,
    parameter logic [31:0] CTRL_ADDR        = 32'h10,
    parameter logic [31:0] STATUS_ADDR      = 32'h14,
    parameter int unsigned STATUS_VALID_BIT = 1,
    parameter int unsigned CNT_W            = 12,
    parameter int unsigned POLL_LIMIT       = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [31:0]               cmd_i,
    input  logic [AHB_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_W-1:0]          word_cnt_i,
    input  logic                      poll_en_i,
    input  logic [31:0]               src_data_i,
    input  logic                      src_valid_i,
    output logic                      src_ready_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    output logic                      hsel_o,
    output logic                      hwrite_o,
    output logic [1:0]                htrans_o,
    output logic [2:0]                hsize_o,
    input  logic                      hreadyout_i,
    input  logic                      hresp_i,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [31:0]               status_o
);
    localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR_ADDR, S_WR_DATA, S_CMD_ADDR,
        S_CMD_DATA, S_POLL_ADDR, S_POLL_DATA, S_DONE, S_ERR
    } state_t;

    state_t                    r_state, w_next;
    logic [31:0]               r_cmd, r_hold, r_status;
    logic [AHB_ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]          r_cnt, r_idx;
    logic                      r_poll_en;
    logic [PCW-1:0]            r_poll_cnt;

    logic [AHB_ADDR_WIDTH-1:0] w_wr_addr, w_addr;
    logic [31:0]               w_word, w_rd_lane;
    logic                      w_dp_ok, w_idx_last, w_poll_last, w_stat_vld;

    // Address arithmetic wraps modulo 2^AHB_ADDR_WIDTH.
    assign w_wr_addr   = r_base + AHB_ADDR_WIDTH'({r_idx, 2'b00});
    assign w_rd_lane   = STATUS_ADDR[2] ? hrdata_i[63:32] : hrdata_i[31:0];
    assign w_stat_vld  = w_rd_lane[STATUS_VALID_BIT];
    assign w_dp_ok     = hreadyout_i & ~hresp_i;
    assign w_idx_last  = ((r_idx + CNT_W'(1)) == r_cnt);
    assign w_poll_last = (r_poll_cnt == PCW'(POLL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_hold     <= '0;
            r_status   <= '0;
            r_base     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_poll_en  <= 1'b0;
            r_poll_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cmd      <= cmd_i;
                        r_base     <= base_addr_i & ~AHB_ADDR_WIDTH'(3);
                        r_cnt      <= word_cnt_i;
                        r_poll_en  <= poll_en_i;
                        r_idx      <= '0;
                        r_poll_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (src_valid_i) r_hold <= src_data_i;
                end
                S_WR_DATA: begin
                    if (w_dp_ok) r_idx <= r_idx + CNT_W'(1);
                end
                S_POLL_DATA: begin
                    if (w_dp_ok) begin
                        r_status <= w_rd_lane;
                        if (!w_stat_vld) r_poll_cnt <= r_poll_cnt + PCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the state so that a stalled phase keeps every
    // bus signal stable and reset puts the bus straight back to IDLE.
    always_comb begin
        w_next      = r_state;
        w_addr      = '0;
        w_word      = '0;
        src_ready_o = 1'b0;
        hsel_o      = 1'b0;
        htrans_o    = 2'b00;
        hwrite_o    = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = (word_cnt_i != '0) ? S_FETCH : S_CMD_ADDR;
            end
            S_FETCH: begin
                src_ready_o = 1'b1;
                if (src_valid_i) w_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                hsel_o   = 1'b1;
                htrans_o = 2'b10;
                hwrite_o = 1'b1;
                w_addr   = w_wr_addr;
                if (hreadyout_i) w_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                hsel_o = 1'b1;
                w_addr = w_wr_addr;
                w_word = r_hold;
                if (hresp_i)          w_next = S_ERR;
                else if (hreadyout_i) w_next = w_idx_last ? S_CMD_ADDR : S_FETCH;
            end
            S_CMD_ADDR: begin
                hsel_o   = 1'b1;
                htrans_o = 2'b10;
                hwrite_o = 1'b1;
                w_addr   = AHB_ADDR_WIDTH'(CTRL_ADDR);
                if (hreadyout_i) w_next = S_CMD_DATA;
            end
            S_CMD_DATA: begin
                hsel_o = 1'b1;
                w_addr = AHB_ADDR_WIDTH'(CTRL_ADDR);
                w_word = r_cmd;
                if (hresp_i)          w_next = S_ERR;
                else if (hreadyout_i) w_next = r_poll_en ? S_POLL_ADDR : S_DONE;
            end
            S_POLL_ADDR: begin
                hsel_o   = 1'b1;
                htrans_o = 2'b10;
                w_addr   = AHB_ADDR_WIDTH'(STATUS_ADDR);
                if (hreadyout_i) w_next = S_POLL_DATA;
            end
            S_POLL_DATA: begin
                hsel_o = 1'b1;
                w_addr = AHB_ADDR_WIDTH'(STATUS_ADDR);
                if (hresp_i)          w_next = S_ERR;
                else if (hreadyout_i) begin
                    if (w_stat_vld)       w_next = S_DONE;
                    else if (w_poll_last) w_next = S_ERR;
                    else                  w_next = S_POLL_ADDR;
                end
            end
            S_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                busy_o = 1'b0;
                err_o  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy_o = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign haddr_o  = w_addr;
    assign hsize_o  = 3'b010;
    assign status_o = r_status;
    // 32-bit write data rides on the lane picked by address bit 2.
    assign hwdata_o = w_addr[2] ? AHB_DATA_WIDTH'({w_word, 32'h0})
                                : AHB_DATA_WIDTH'(w_word);
endmodule
